aes_round_controller: RTL and testbench
=======================================

# aes_round_controller

Iterative AES-128 encryption sequencer for the one-round-per-cycle datapath. It accepts a plaintext and cipher key on a start handshake and performs the initial AddRoundKey. It then drives the shared round datapath (key expansion, SubBytes, ShiftRows, MixColumns, AddRoundKey) for rounds 1–9 and the final-round datapath (no MixColumns) for round 10. It sits between the host-side request interface and the round logic and owns all round state registers.

## Interface
Parameters: none (AES-128 only, 10 rounds fixed).

- clock  in  1  single system clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  request; sampled only while ready=1
- plaintext  in  128  input block, sampled with start
- key  in  128  cipher key, sampled with start
- ready  out  1  high when idle and able to accept start
- busy  out  1  high while rounds are in progress
- done  out  1  one-cycle pulse: ciphertext valid
- ciphertext  out  128  result register, held until next accepted start
- rnd_count  out  4  round number to datapath (1..10), drives key-schedule Rcon
- rnd_data  out  128  current state to datapath
- rnd_key  out  128  previous round key to datapath
- rnd_keyout  in  128  next round key from round datapath (rounds 1–9)
- rnd_out  in  128  round result from round datapath (rounds 1–9)
- fin_out  in  128  round-10 result from final-round datapath
- abort  in  1  present only with AES_ABORT_EN

## Operation
- Registers: state_reg[127:0], key_reg[127:0], round_reg[3:0], fsm, ciphertext.
- rnd_data=state_reg, rnd_key=key_reg, rnd_count=round_reg. These are direct register outputs with no logic.
- FSM states:
  - IDLE: ready=1. start=1 → state_reg<=plaintext^key, key_reg<=key, round_reg<=1, go RUN.
  - RUN: busy=1. Each edge: state_reg<=rnd_out, key_reg<=rnd_keyout, round_reg<=round_reg+1. The edge at round_reg=9 goes to FINAL (round_reg becomes 10).
  - FINAL: busy=1. ciphertext<=fin_out, go DONE.
  - DONE: done=1, busy=0, ready=0, for exactly one cycle; then IDLE.
- start outside IDLE is ignored; it is not queued.
- round_reg never exceeds 10 and never wraps. It returns to 0 on reset and on entry to IDLE.
- ciphertext changes only on the FINAL edge and on reset.

## Timing
- Reset values: ready=1 (fsm=IDLE), busy=0, done=0, ciphertext=0, state_reg=0, key_reg=0, round_reg=0.
- Latency: start sampled at edge E0. Rounds 1–9 are registered at E1..E9, final at E10. done is high in the cycle after E10. ready is high again after E11.
- Throughput: one block per 12 cycles. A start held high continuously is accepted on the first IDLE cycle after DONE.
- Datapath inputs are used the same cycle they are produced, so the datapath path is single-cycle combinational.
- reset asserted in any state: on the next edge the block goes to IDLE and all registers take reset values. This includes a reset mid-run and a reset coincident with start; reset wins.

## Configuration
- AES_ABORT_EN defined: the abort port exists.
  - abort=1 in RUN or FINAL: the next edge goes to IDLE and round_reg<=0.
  - No done pulse; ciphertext keeps its previous value.
  - abort in IDLE or DONE has no effect.
  - If abort and reset are both high, reset wins.
- AES_ABORT_EN undefined: no abort port, and a run always completes.

## Test plan
- FIPS-197 App. B: plaintext=3243f6a8885a308d313198a2e0370734, key=2b7e151628aed2a6abf7158809cf4f3c → done exactly 10 edges after start sample, ciphertext=3925841d02dc09fbdc118597196a0b32.
- FIPS-197 C.1: plaintext=00112233445566778899aabbccddeeff, key=000102030405060708090a0b0c0d0e0f → ciphertext=69c4e0d86a7b0430d8cdb78070b4c55a. Across the run, rnd_count steps 1,2,…,10 and busy is high for 10 cycles.
- start pulsed during RUN (round 5) → ignored. The same ciphertext and one done pulse result, then ready=1.
- start held high across two blocks → second block accepted on the first IDLE cycle after DONE. Both ciphertexts are correct, and the done pulses are 12 cycles apart.
- reset asserted at round 6 → next cycle ready=1, busy=0, ciphertext=0, no done. A following C.1 run is correct.
- With AES_ABORT_EN, abort at round 3 after a prior App. B run → no done, and ciphertext stays 3925841d…0b32.

Source files
------------

// File: rtl/aes_round_controller.sv
// Iterative AES-128 encryption sequencer: initial AddRoundKey, rounds 1-9, final round 10.
// Optional abort port and behaviour are enabled with the AES_ABORT_EN macro.
module aes_round_controller (
    input  logic         clock,
    input  logic         reset,
    input  logic         start,
`ifdef AES_ABORT_EN
    input  logic         abort,
`endif
    input  logic [127:0] plaintext,
    input  logic [127:0] key,
    output logic         ready,
    output logic         busy,
    output logic         done,
    output logic [127:0] ciphertext,
    output logic [3:0]   rnd_count,
    output logic [127:0] rnd_data,
    output logic [127:0] rnd_key,
    input  logic [127:0] rnd_keyout,
    input  logic [127:0] rnd_out,
    input  logic [127:0] fin_out
);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StFinal,
        StDone
    } fsm_e;

    fsm_e         fsm_q, fsm_d;
    logic [127:0] state_reg, state_d;
    logic [127:0] key_reg, key_d;
    logic [3:0]   round_reg, round_d;
    logic [127:0] ct_reg, ct_d;
    logic         abort_req;

`ifdef AES_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    assign rnd_data   = state_reg;
    assign rnd_key    = key_reg;
    assign rnd_count  = round_reg;
    assign ciphertext = ct_reg;

    always_comb begin
        fsm_d   = fsm_q;
        state_d = state_reg;
        key_d   = key_reg;
        round_d = round_reg;
        ct_d    = ct_reg;
        ready   = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        unique case (fsm_q)
            StIdle: begin
                ready = 1'b1;
                if (start) begin
                    state_d = plaintext ^ key;
                    key_d   = key;
                    round_d = 4'd1;
                    fsm_d   = StRun;
                end
            end
            StRun: begin
                busy = 1'b1;
                if (abort_req) begin
                    round_d = 4'd0;
                    fsm_d   = StIdle;
                end else begin
                    state_d = rnd_out;
                    key_d   = rnd_keyout;
                    round_d = round_reg + 4'd1;
                    // >= keeps the counter bounded at 10 even from a corrupted value
                    if (round_reg >= 4'd9) begin
                        round_d = 4'd10;
                        fsm_d   = StFinal;
                    end
                end
            end
            StFinal: begin
                busy = 1'b1;
                if (abort_req) begin
                    round_d = 4'd0;
                    fsm_d   = StIdle;
                end else begin
                    ct_d  = fin_out;
                    fsm_d = StDone;
                end
            end
            StDone: begin
                done    = 1'b1;
                round_d = 4'd0;
                fsm_d   = StIdle;
            end
            default: begin
                round_d = 4'd0;
                fsm_d   = StIdle;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            fsm_q     <= StIdle;
            state_reg <= '0;
            key_reg   <= '0;
            round_reg <= '0;
            ct_reg    <= '0;
        end else begin
            fsm_q     <= fsm_d;
            state_reg <= state_d;
            key_reg   <= key_d;
            round_reg <= round_d;
            ct_reg    <= ct_d;
        end
    end

endmodule

// File: tb/tb_aes_round_controller.sv
// Directed bench for aes_round_controller; a behavioural AES round model plays the datapath.
module tb_aes_round_controller;

    localparam logic [127:0] PtB  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] KeyB = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] CtB  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PtC  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KeyC = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CtC  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic         clock, reset, start, abort;
    logic [127:0] plaintext, key;
    logic         ready, busy, done;
    logic [127:0] ciphertext, rnd_data, rnd_key, rnd_keyout, rnd_out, fin_out;
    logic [3:0]   rnd_count;

    int tests = 0;
    int fails = 0;

    aes_round_controller dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
`ifdef AES_ABORT_EN
        .abort      (abort),
`endif
        .plaintext  (plaintext),
        .key        (key),
        .ready      (ready),
        .busy       (busy),
        .done       (done),
        .ciphertext (ciphertext),
        .rnd_count  (rnd_count),
        .rnd_data   (rnd_data),
        .rnd_key    (rnd_key),
        .rnd_keyout (rnd_keyout),
        .rnd_out    (rnd_out),
        .fin_out    (fin_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ---------------- AES reference datapath ----------------
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [7:0] sq, inv;
        sq  = b;
        inv = 8'h01;
        // b^254 = b^2 * b^4 * ... * b^128 (multiplicative inverse, 0 maps to 0)
        for (int i = 1; i < 8; i++) begin
            sq  = gmul(sq, sq);
            inv = gmul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
               ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] sub_shift(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(r+4*c) -: 8] = sbox(s[127-8*(r+4*((c+r)%4)) -: 8]);
        return o;
    endfunction

    function automatic logic [127:0] mix(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0] a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 8] = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
            o[119-32*c -: 8] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
            o[111-32*c -: 8] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
            o[103-32*c -: 8] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
        end
        return o;
    endfunction

    function automatic logic [127:0] key_expand(input logic [127:0] k, input logic [3:0] rnd);
        logic [7:0]  rcon;
        logic [31:0] w3, t, n0, n1, n2, n3;
        rcon = 8'h01;
        for (int i = 1; i < int'(rnd); i++) rcon = xtime(rcon);
        w3 = k[31:0];
        t  = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])} ^ {rcon, 24'h0};
        n0 = k[127:96] ^ t;
        n1 = k[95:64] ^ n0;
        n2 = k[63:32] ^ n1;
        n3 = w3 ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    assign rnd_keyout = key_expand(rnd_key, rnd_count);
    assign rnd_out    = mix(sub_shift(rnd_data)) ^ rnd_keyout;
    assign fin_out    = sub_shift(rnd_data) ^ rnd_keyout;

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Starts a block and waits (bounded) for done; edges counts clock edges after the start edge.
    task automatic run_block(input logic [127:0] pt, input logic [127:0] k, output int edges);
        start     = 1'b1;
        plaintext = pt;
        key       = k;
        tick();
        start = 1'b0;
        edges = 0;
        while (!done && edges < 20) begin
            tick();
            edges++;
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tests++; if (ready !== 1'b1) begin fails++; $display("FAIL reset_ready got %b want 1", ready); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
        tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done got %b want 0", done); end
        tests++; if (ciphertext !== 128'h0) begin fails++; $display("FAIL reset_ct got %h want 0", ciphertext); end
        tests++; if (rnd_count !== 4'd0) begin fails++; $display("FAIL reset_round got %0d want 0", rnd_count); end
        tests++; if (rnd_data !== 128'h0) begin fails++; $display("FAIL reset_state got %h want 0", rnd_data); end
        tests++; if (rnd_key !== 128'h0) begin fails++; $display("FAIL reset_key got %h want 0", rnd_key); end
    endtask

    task automatic test_fips_b();
        int edges;
        start     = 1'b1;
        plaintext = PtB;
        key       = KeyB;
        tick();
        start = 1'b0;
        tests++; if (rnd_data !== (PtB ^ KeyB)) begin fails++; $display("FAIL b_initial_ark got %h want %h", rnd_data, PtB ^ KeyB); end
        tests++; if (rnd_key !== KeyB) begin fails++; $display("FAIL b_key_load got %h want %h", rnd_key, KeyB); end
        tests++; if (rnd_count !== 4'd1 || busy !== 1'b1 || ready !== 1'b0) begin
            fails++; $display("FAIL b_first_round got cnt=%0d busy=%b ready=%b want 1 1 0", rnd_count, busy, ready); end
        edges = 0;
        while (!done && edges < 20) begin
            tick();
            edges++;
        end
        tests++; if (edges !== 10) begin fails++; $display("FAIL b_latency got %0d want 10", edges); end
        tests++; if (ciphertext !== CtB) begin fails++; $display("FAIL b_ct got %h want %h", ciphertext, CtB); end
        tests++; if (ready !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL b_done_flags got ready=%b busy=%b want 0 0", ready, busy); end
        tick();
        tests++; if (done !== 1'b0 || ready !== 1'b1 || rnd_count !== 4'd0) begin
            fails++; $display("FAIL b_back_idle got done=%b ready=%b cnt=%0d want 0 1 0", done, ready, rnd_count); end
        tests++; if (ciphertext !== CtB) begin fails++; $display("FAIL b_ct_hold got %h want %h", ciphertext, CtB); end
    endtask

    task automatic test_fips_c1();
        int i, nbusy;
        start     = 1'b1;
        plaintext = PtC;
        key       = KeyC;
        tick();
        start = 1'b0;
        i     = 0;
        nbusy = 0;
        while (!done && i < 20) begin
            if (busy) begin
                nbusy++;
                tests++; if (rnd_count !== nbusy[3:0]) begin
                    fails++; $display("FAIL c1_round_seq got %0d want %0d", rnd_count, nbusy); end
            end
            tick();
            i++;
        end
        tests++; if (nbusy !== 10) begin fails++; $display("FAIL c1_busy_cycles got %0d want 10", nbusy); end
        tests++; if (ciphertext !== CtC) begin fails++; $display("FAIL c1_ct got %h want %h", ciphertext, CtC); end
        tick();
    endtask

    task automatic test_start_ignored();
        int n, pulses;
        start     = 1'b1;
        plaintext = PtC;
        key       = KeyC;
        tick();
        start = 1'b0;
        n = 0;
        while (rnd_count != 4'd5 && n < 20) begin
            tick();
            n++;
        end
        tests++; if (rnd_count !== 4'd5) begin fails++; $display("FAIL ign_reach_round5 got %0d want 5", rnd_count); end
        start     = 1'b1;
        plaintext = PtB;
        key       = KeyB;
        tick();
        start = 1'b0;
        tests++; if (rnd_count !== 4'd6) begin fails++; $display("FAIL ign_no_restart got %0d want 6", rnd_count); end
        n      = 0;
        pulses = 0;
        while (!ready && n < 20) begin
            if (done) pulses++;
            tick();
            n++;
        end
        tests++; if (pulses !== 1) begin fails++; $display("FAIL ign_done_pulses got %0d want 1", pulses); end
        tests++; if (ciphertext !== CtC) begin fails++; $display("FAIL ign_ct got %h want %h", ciphertext, CtC); end
        tests++; if (ready !== 1'b1) begin fails++; $display("FAIL ign_ready got %b want 1", ready); end
    endtask

    task automatic test_back_to_back();
        int t, nd, t1, t2;
        logic [127:0] ct1, ct2;
        t1 = 0; t2 = 0; ct1 = '0; ct2 = '0;
        start     = 1'b1;
        plaintext = PtB;
        key       = KeyB;
        tick();
        plaintext = PtC;
        key       = KeyC;
        t  = 0;
        nd = 0;
        while (nd < 2 && t < 40) begin
            tick();
            t++;
            if (done) begin
                if (nd == 0) begin
                    t1  = t;
                    ct1 = ciphertext;
                end else begin
                    t2    = t;
                    ct2   = ciphertext;
                    start = 1'b0;
                end
                nd++;
            end
        end
        start = 1'b0;
        tests++; if (nd !== 2) begin fails++; $display("FAIL b2b_done_count got %0d want 2", nd); end
        tests++; if (t2 - t1 !== 12) begin fails++; $display("FAIL b2b_gap got %0d want 12", t2 - t1); end
        tests++; if (ct1 !== CtB) begin fails++; $display("FAIL b2b_ct1 got %h want %h", ct1, CtB); end
        tests++; if (ct2 !== CtC) begin fails++; $display("FAIL b2b_ct2 got %h want %h", ct2, CtC); end
        tick();
        tests++; if (ready !== 1'b1 || busy !== 1'b0) begin
            fails++; $display("FAIL b2b_idle got ready=%b busy=%b want 1 0", ready, busy); end
    endtask

    task automatic test_reset_midrun();
        int n, edges;
        start     = 1'b1;
        plaintext = PtB;
        key       = KeyB;
        tick();
        start = 1'b0;
        n = 0;
        while (rnd_count != 4'd6 && n < 20) begin
            tick();
            n++;
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tests++; if (ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
            fails++; $display("FAIL rst_mid_flags got ready=%b busy=%b done=%b want 1 0 0", ready, busy, done); end
        tests++; if (ciphertext !== 128'h0 || rnd_count !== 4'd0) begin
            fails++; $display("FAIL rst_mid_regs got ct=%h cnt=%0d want 0 0", ciphertext, rnd_count); end
        reset     = 1'b1;
        start     = 1'b1;
        plaintext = PtC;
        key       = KeyC;
        tick();
        reset = 1'b0;
        start = 1'b0;
        tests++; if (ready !== 1'b1 || rnd_count !== 4'd0 || rnd_data !== 128'h0) begin
            fails++; $display("FAIL rst_vs_start got ready=%b cnt=%0d state=%h want 1 0 0", ready, rnd_count, rnd_data); end
        run_block(PtC, KeyC, edges);
        tests++; if (edges !== 10 || ciphertext !== CtC) begin
            fails++; $display("FAIL rst_then_c1 got edges=%0d ct=%h want 10 %h", edges, ciphertext, CtC); end
        tick();
    endtask

`ifdef AES_ABORT_EN
    task automatic test_abort();
        int n, edges, pulses;
        run_block(PtB, KeyB, edges);
        tests++; if (ciphertext !== CtB) begin fails++; $display("FAIL abort_prior_ct got %h want %h", ciphertext, CtB); end
        tick();
        start     = 1'b1;
        plaintext = PtC;
        key       = KeyC;
        tick();
        start = 1'b0;
        n = 0;
        while (rnd_count != 4'd3 && n < 20) begin
            tick();
            n++;
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        tests++; if (ready !== 1'b1 || busy !== 1'b0 || rnd_count !== 4'd0) begin
            fails++; $display("FAIL abort_idle got ready=%b busy=%b cnt=%0d want 1 0 0", ready, busy, rnd_count); end
        pulses = 0;
        for (int i = 0; i < 15; i++) begin
            if (done) pulses++;
            tick();
        end
        tests++; if (pulses !== 0) begin fails++; $display("FAIL abort_no_done got %0d want 0", pulses); end
        tests++; if (ciphertext !== CtB) begin fails++; $display("FAIL abort_ct_kept got %h want %h", ciphertext, CtB); end
    endtask
`endif

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        abort     = 1'b0;
        plaintext = '0;
        key       = '0;
        test_reset();
        test_fips_b();
        test_fips_c1();
        test_start_ignored();
        test_back_to_back();
        test_reset_midrun();
`ifdef AES_ABORT_EN
        test_abort();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
